// File: rtl/mat_vec_mac.sv
// mat_vec_mac: captures a matrix/vector pair and streams one signed dot product per row
// through a single time-shared multiply-accumulate unit over a valid/ready handshake.
module mat_vec_mac #(
    parameter int DATA_SIZE   = 16,
    parameter int COLUMN_SIZE = 8,
    parameter int ROW_SIZE    = 8,
    parameter int ACC_SIZE    = 35,
    localparam int COL_W      = COLUMN_SIZE > 1 ? $clog2(COLUMN_SIZE) : 1,
    localparam int IDX_SIZE   = ROW_SIZE > 1 ? $clog2(ROW_SIZE) : 1
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [DATA_SIZE*COLUMN_SIZE*ROW_SIZE-1:0] matIn,
    input  logic                                      matValid,
    input  logic [DATA_SIZE*COLUMN_SIZE-1:0]          vecIn,
    output logic signed [ACC_SIZE-1:0]                resOut,
    output logic [IDX_SIZE-1:0]                       resIdx,
    output logic                                      resValid,
    input  logic                                      resReady,
    output logic                                      busy,
    output logic                                      doneFlag,
    output logic                                      ovrFlag,
    input  logic                                      clrOvr
);
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t state;
    logic signed [DATA_SIZE-1:0]   m [COLUMN_SIZE][ROW_SIZE];
    logic signed [DATA_SIZE-1:0]   v [COLUMN_SIZE];
    logic [ACC_SIZE-1:0]           acc;
    logic [COL_W-1:0]              col;
    logic [IDX_SIZE-1:0]           row;
    logic signed [2*DATA_SIZE-1:0] prod;
    logic [ACC_SIZE-1:0]           sum;
    logic                          last_col;
    logic                          last_row;
    assign prod     = m[col][row] * v[col];
    assign sum      = acc + {{(ACC_SIZE-2*DATA_SIZE){prod[2*DATA_SIZE-1]}}, prod};
    assign last_col = col == COL_W'(COLUMN_SIZE-1);
    assign last_row = row == IDX_SIZE'(ROW_SIZE-1);
    assign busy     = state != IDLE;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            col      <= '0;
            row      <= '0;
            resOut   <= '0;
            resIdx   <= '0;
            resValid <= 1'b0;
            doneFlag <= 1'b0;
            ovrFlag  <= 1'b0;
            for (int c = 0; c < COLUMN_SIZE; c++) begin
                v[c] <= '0;
                for (int r = 0; r < ROW_SIZE; r++) m[c][r] <= '0;
            end
        end else begin
            doneFlag <= 1'b0;
            // a new overrun takes priority over a simultaneous clear
            if (matValid && state != IDLE) ovrFlag <= 1'b1;
            else if (clrOvr) ovrFlag <= 1'b0;
            case (state)
                IDLE: if (matValid) begin
                    for (int c = 0; c < COLUMN_SIZE; c++) begin
                        v[c] <= vecIn[c*DATA_SIZE +: DATA_SIZE];
                        for (int r = 0; r < ROW_SIZE; r++)
                            m[c][r] <= matIn[(c*ROW_SIZE+r)*DATA_SIZE +: DATA_SIZE];
                    end
                    row   <= '0;
                    col   <= '0;
                    acc   <= '0;
                    state <= MAC;
                end
                MAC: begin
                    acc <= sum;
                    col <= col + 1'b1;
                    if (last_col) begin
                        resOut   <= sum;
                        resIdx   <= row;
                        resValid <= 1'b1;
                        state    <= OUT;
                    end
                end
                OUT: if (resReady) begin
                    resValid <= 1'b0;
                    col      <= '0;
                    acc      <= '0;
                    if (last_row) begin
                        doneFlag <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        row   <= row + 1'b1;
                        state <= MAC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_vec_mac.sv
// tb_mat_vec_mac: scoreboard-driven bench; expected rows are queued when a matrix is sent
// and popped as the DUT hands results over the valid/ready interface.
module tb_mat_vec_mac;
    localparam int D = 16, C = 8, R = 8, A = 35;
    typedef struct {
        int           idx;
        logic [A-1:0] res;
    } exp_t;
    logic           clock = 0;
    logic           reset = 1;
    logic [D*C*R-1:0] matIn = '0;
    logic           matValid = 0;
    logic [D*C-1:0] vecIn = '0;
    logic [A-1:0]   resOut;
    logic [2:0]     resIdx;
    logic           resValid;
    logic           resReady = 1;
    logic           busy;
    logic           doneFlag;
    logic           ovrFlag;
    logic           clrOvr = 0;
    logic [D-1:0]   tm [C][R];
    logic [D-1:0]   tv [C];
    exp_t           sb[$];
    int             checks = 0;
    int             failures = 0;
    int             cyc = 0;

    mat_vec_mac dut (
        .clock(clock), .reset(reset), .matIn(matIn), .matValid(matValid), .vecIn(vecIn),
        .resOut(resOut), .resIdx(resIdx), .resValid(resValid), .resReady(resReady),
        .busy(busy), .doneFlag(doneFlag), .ovrFlag(ovrFlag), .clrOvr(clrOvr)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [A-1:0] model_row(input int r);
        longint s = 0;
        for (int c = 0; c < C; c++) s += longint'($signed(tm[c][r])) * longint'($signed(tv[c]));
        return s[A-1:0];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pack();
        for (int c = 0; c < C; c++) begin
            vecIn[c*D +: D] = tv[c];
            for (int r = 0; r < R; r++) matIn[(c*R+r)*D +: D] = tm[c][r];
        end
    endtask

    task automatic randomize_data();
        for (int c = 0; c < C; c++) begin
            tv[c] = 16'($urandom);
            for (int r = 0; r < R; r++) tm[c][r] = 16'($urandom);
        end
    endtask

    task automatic send(input bit push);
        if (push) for (int r = 0; r < R; r++) sb.push_back(exp_t'{idx: r, res: model_row(r)});
        pack();
        matValid = 1;
        step();
        matValid = 0;
    endtask

    task automatic drain(input string name, input int stall_idx, input int stop);
        int n = 0;
        int stall = 0;
        logic [A-1:0] held = '0;
        exp_t e;
        resReady = 1;
        while (sb.size() > stop && n < 2000) begin
            if (resValid && stall_idx >= 0 && int'(resIdx) == stall_idx && stall < 5) begin
                resReady = 0;
                if (stall > 0) begin
                    checks++;
                    if (resOut !== held || int'(resIdx) !== stall_idx) begin
                        failures++;
                        $display("FAIL %s hold: got idx=%0d res=%0d, want idx=%0d res=%0d",
                                 name, resIdx, $signed(resOut), stall_idx, $signed(held));
                    end
                end else held = resOut;
                stall++;
            end else begin
                resReady = 1;
                if (resValid) begin
                    e = sb.pop_front();
                    checks++;
                    if (resOut !== e.res || resIdx !== 3'(e.idx)) begin
                        failures++;
                        $display("FAIL %s result: got idx=%0d res=%0d, want idx=%0d res=%0d",
                                 name, resIdx, $signed(resOut), e.idx, $signed(e.res));
                    end
                end
            end
            step();
            n++;
        end
        resReady = 1;
        if (sb.size() > stop) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: got %0d results pending, want %0d", name, sb.size(), stop);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) step();
        checks++;
        if ({resOut, resIdx, resValid, busy, doneFlag, ovrFlag} !== '0) begin
            failures++;
            $display("FAIL reset_state: got res=%0d idx=%0d v=%b busy=%b done=%b ovr=%b, want all 0",
                     resOut, resIdx, resValid, busy, doneFlag, ovrFlag);
        end
        reset = 0;
        step();
    endtask

    task automatic test_defaults();
        int t0;
        int k = 0;
        for (int c = 0; c < C; c++) begin
            tv[c] = 16'(c + 1);
            for (int r = 0; r < R; r++) tm[c][r] = 16'd1;
        end
        for (int r = 0; r < R; r++) sb.push_back(exp_t'{idx: r, res: A'(36)});
        send(0);
        t0 = cyc;
        while (!resValid && k < 50) begin
            step();
            k++;
        end
        checks++;
        if (cyc - t0 + 1 !== 9 || busy !== 1) begin
            failures++;
            $display("FAIL first_valid: got resValid at edge T+%0d busy=%b, want T+9 busy=1", cyc - t0 + 1, busy);
        end
        drain("defaults", -1, 0);
        checks++;
        if (doneFlag !== 1 || cyc - t0 !== 72) begin
            failures++;
            $display("FAIL done_latency: got doneFlag=%b after %0d cycles, want 1 after 72", doneFlag, cyc - t0);
        end
        step();
        checks++;
        if (doneFlag !== 0 || busy !== 0) begin
            failures++;
            $display("FAIL done_pulse: got doneFlag=%b busy=%b, want 0 0", doneFlag, busy);
        end
    endtask

    task automatic test_signed();
        for (int c = 0; c < C; c++) begin
            tv[c] = 16'h7FFF;
            for (int r = 0; r < R; r++) tm[c][r] = 16'hFFFF;
        end
        for (int r = 0; r < R; r++) sb.push_back(exp_t'{idx: r, res: A'(-262136)});
        send(0);
        drain("signed_neg", -1, 0);
        for (int c = 0; c < C; c++) begin
            tv[c] = 16'h8000;
            for (int r = 0; r < R; r++) tm[c][r] = 16'h8000;
        end
        for (int r = 0; r < R; r++) sb.push_back(exp_t'{idx: r, res: 35'h2_0000_0000});
        send(0);
        drain("signed_max", -1, 0);
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < C; c++) begin
            tv[c] = 16'd1;
            for (int r = 0; r < R; r++) tm[c][r] = 16'(r);
        end
        for (int r = 0; r < R; r++) sb.push_back(exp_t'{idx: r, res: A'(8 * r)});
        send(0);
        drain("backpressure", 3, 0);
    endtask

    task automatic test_overrun();
        randomize_data();
        send(1);
        drain("overrun_a", -1, 6);
        repeat (3) step();
        randomize_data();
        send(0);
        checks++;
        if (ovrFlag !== 1) begin
            failures++;
            $display("FAIL overrun_set: got ovrFlag=%b, want 1", ovrFlag);
        end
        drain("overrun_a", -1, 0);
        clrOvr = 1;
        step();
        clrOvr = 0;
        checks++;
        if (ovrFlag !== 0) begin
            failures++;
            $display("FAIL overrun_clear: got ovrFlag=%b, want 0", ovrFlag);
        end
        randomize_data();
        send(1);
        repeat (2) step();
        randomize_data();
        clrOvr = 1;
        send(0);
        clrOvr = 0;
        checks++;
        if (ovrFlag !== 1) begin
            failures++;
            $display("FAIL overrun_set_wins: got ovrFlag=%b, want 1", ovrFlag);
        end
        drain("overrun_b", -1, 0);
        clrOvr = 1;
        step();
        clrOvr = 0;
    endtask

    task automatic test_back_to_back();
        randomize_data();
        send(1);
        drain("b2b_first", -1, 0);
        checks++;
        if (doneFlag !== 1 || busy !== 0) begin
            failures++;
            $display("FAIL b2b_done_cycle: got doneFlag=%b busy=%b, want 1 0", doneFlag, busy);
        end
        randomize_data();
        send(1);
        checks++;
        if (ovrFlag !== 0 || busy !== 1) begin
            failures++;
            $display("FAIL b2b_accept: got ovrFlag=%b busy=%b, want 0 1", ovrFlag, busy);
        end
        drain("b2b_second", -1, 0);
        checks++;
        if (ovrFlag !== 0) begin
            failures++;
            $display("FAIL b2b_ovr: got ovrFlag=%b, want 0", ovrFlag);
        end
    endtask

    task automatic test_final_drop();
        int k = 0;
        exp_t e;
        randomize_data();
        send(1);
        drain("final_drop", -1, 1);
        while (!resValid && k < 50) begin
            step();
            k++;
        end
        e = sb.pop_front();
        checks++;
        if (resValid !== 1 || resOut !== e.res || resIdx !== 3'(e.idx)) begin
            failures++;
            $display("FAIL final_row: got v=%b idx=%0d res=%0d, want v=1 idx=%0d res=%0d",
                     resValid, resIdx, $signed(resOut), e.idx, $signed(e.res));
        end
        randomize_data();
        pack();
        matValid = 1;
        step();
        matValid = 0;
        checks++;
        if (doneFlag !== 1 || ovrFlag !== 1 || busy !== 0) begin
            failures++;
            $display("FAIL final_drop_flags: got done=%b ovr=%b busy=%b, want 1 1 0", doneFlag, ovrFlag, busy);
        end
        repeat (12) step();
        checks++;
        if (resValid !== 0 || busy !== 0) begin
            failures++;
            $display("FAIL final_drop_ignored: got resValid=%b busy=%b, want 0 0", resValid, busy);
        end
        clrOvr = 1;
        step();
        clrOvr = 0;
    endtask

    task automatic test_reset_mid();
        randomize_data();
        send(1);
        drain("reset_mid", -1, 4);
        repeat (2) step();
        randomize_data();
        pack();
        matValid = 1;
        step();
        matValid = 0;
        checks++;
        if (ovrFlag !== 1 || busy !== 1) begin
            failures++;
            $display("FAIL reset_mid_pre: got ovrFlag=%b busy=%b, want 1 1", ovrFlag, busy);
        end
        #3 reset = 1;
        #1;
        checks++;
        if ({resOut, resIdx, resValid, busy, doneFlag, ovrFlag} !== '0) begin
            failures++;
            $display("FAIL reset_async: got res=%0d idx=%0d v=%b busy=%b done=%b ovr=%b, want all 0",
                     resOut, resIdx, resValid, busy, doneFlag, ovrFlag);
        end
        sb.delete();
        step();
        reset = 0;
        step();
        randomize_data();
        send(1);
        drain("after_reset", -1, 0);
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_signed();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_final_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
